// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : RAM port-1 read bus plus decode valid/ready handshake
// Revision : 1.0
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (
        output mem_addr, mem_cs, mem_we, mem_oe,
        input  mem_rdata,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  mem_addr, mem_cs, mem_we, mem_oe,
        output mem_rdata,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC-driven instruction RAM reader with prefetch FIFO and redirect
//            flush. Define IFU_PERF_CNT_EN to add fetch/stall counters.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_fetch_en,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
`ifdef IFU_PERF_CNT_EN
    output logic [15:0]           o_perf_fetch_cnt,
    output logic [15:0]           o_perf_stall_cnt,
`endif
    instr_fetch_unit_if.master    bus
);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_EW = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [c_CW-1:0]       r_count;
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_EW-1:0]       r_mem [FIFO_DEPTH];

    logic w_req;
    logic w_valid;
    logic w_pop;

    // Full test uses the registered count only, so a same-cycle pop never frees a slot
    assign w_req   = (r_state == S_RUN) && (r_count < c_CW'(FIFO_DEPTH)) && !i_redirect_valid;
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.instr_ready && !i_redirect_valid;

    assign bus.mem_addr    = r_pc;
    assign bus.mem_cs      = w_req;
    assign bus.mem_oe      = w_req;
    assign bus.mem_we      = 1'b0;
    assign bus.instr_valid = w_valid;
    assign bus.instr_data  = w_valid ? r_mem[r_rd_ptr][DATA_WIDTH-1:0] : '0;
    assign bus.instr_pc    = w_valid ? r_mem[r_rd_ptr][c_EW-1:DATA_WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (w_req) begin
            r_mem[r_wr_ptr] <= {r_pc, bus.mem_rdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (i_fetch_en) r_state <= S_RUN;
                S_RUN:   if (!i_fetch_en) r_state <= i_redirect_valid ? S_IDLE : S_HOLD;
                S_HOLD:  if (i_fetch_en) r_state <= S_RUN;
                default: r_state <= S_IDLE;
            endcase

            if (i_redirect_valid) begin
                r_pc     <= i_redirect_pc;
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_req) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_pc     <= r_pc + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_req, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic w_stall;
    assign w_stall = (r_state == S_RUN) && (r_count == c_CW'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_fetch_cnt <= '0;
            o_perf_stall_cnt <= '0;
        end else begin
            if (w_req && (o_perf_fetch_cnt != 16'hFFFF)) begin
                o_perf_fetch_cnt <= o_perf_fetch_cnt + 16'd1;
            end
            if (w_stall && (o_perf_stall_cnt != 16'hFFFF)) begin
                o_perf_stall_cnt <= o_perf_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench: directed table, corner sequences, random run
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;
    logic       clk;
    logic       rst_n;
    logic       fetch_en;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    instr_fetch_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    instr_fetch_unit #(
        .DATA_WIDTH(16), .ADDR_WIDTH(8), .FIFO_DEPTH(4), .RESET_PC(8'h00)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_fetch_en       (fetch_en),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
`ifdef IFU_PERF_CNT_EN
        .o_perf_fetch_cnt (perf_fetch_cnt),
        .o_perf_stall_cnt (perf_stall_cnt),
`endif
        .bus              (bus)
    );

    logic [15:0] ram [256];
    assign bus.mem_rdata = ram[bus.mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: queue of {pc,data}; fetching happens in cycles after fetch_en was high
    logic [23:0] m_q[$];
    logic [7:0]  m_pc;
    bit          m_run;
    int          m_fc, m_sc;

    logic        o_cs, o_valid;
    logic [7:0]  o_addr, o_pc;
    logic [15:0] o_data;

    task automatic model_reset();
        m_q.delete();
        m_pc  = 8'h00;
        m_run = 1'b0;
        m_fc  = 0;
        m_sc  = 0;
    endtask

    task automatic step(input bit fe, input bit rv, input logic [7:0] rpc, input bit rdy);
        bit req, pop;
        fetch_en        = fe;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        bus.instr_ready = rdy;
        @(negedge clk);
        o_cs = bus.mem_cs; o_addr = bus.mem_addr; o_valid = bus.instr_valid;
        o_data = bus.instr_data; o_pc = bus.instr_pc;
        req = m_run && (m_q.size() < 4) && !rv;
        pop = (m_q.size() != 0) && rdy;
        chk("valid", o_valid, m_q.size() != 0);
        chk("data",  o_data,  (m_q.size() != 0) ? {16'h0, m_q[0][15:0]} : 32'h0);
        chk("ipc",   o_pc,    (m_q.size() != 0) ? {24'h0, m_q[0][23:16]} : 32'h0);
        chk("cs",    o_cs,    req);
        chk("oe",    bus.mem_oe, req);
        chk("addr",  o_addr,  m_pc);
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, (m_fc > 65535) ? 65535 : m_fc);
        chk("perf_stall", perf_stall_cnt, (m_sc > 65535) ? 65535 : m_sc);
`endif
        @(posedge clk);
        if (m_run && m_q.size() == 4) m_sc++;
        if (rv) begin
            m_q.delete();
            m_pc = rpc;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (req) begin
                m_q.push_back({m_pc, ram[m_pc]});
                m_pc = m_pc + 8'd1;
                m_fc++;
            end
        end
        m_run = fe;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; bus.instr_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_cs",    bus.mem_cs, 1'b0);
        chk("rst_addr",  bus.mem_addr, 8'h00);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_data",  bus.instr_data, 16'h0);
        chk("rst_ipc",   bus.instr_pc, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          fe;
        bit          rdy;
        bit          e_valid;
        logic [15:0] e_data;
        logic [7:0]  e_pc;
        bit          e_cs;
        logic [7:0]  e_addr;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int ncs;
        logic [7:0] wrap_addr [4];
        for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + 16'(i);

        rst_n = 1'b0;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; bus.instr_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cs",    bus.mem_cs, 1'b0);
        chk("reset_oe",    bus.mem_oe, 1'b0);
        chk("reset_we",    bus.mem_we, 1'b0);
        chk("reset_addr",  bus.mem_addr, 8'h00);
        chk("reset_valid", bus.instr_valid, 1'b0);
        chk("reset_data",  bus.instr_data, 16'h0);
        chk("reset_ipc",   bus.instr_pc, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming fetch: one cycle to leave IDLE, then one instruction per cycle
        tbl[0] = '{1, 1, 0, 16'h0000, 8'h00, 0, 8'h00};
        tbl[1] = '{1, 1, 0, 16'h0000, 8'h00, 1, 8'h00};
        tbl[2] = '{1, 1, 1, 16'hA000, 8'h00, 1, 8'h01};
        tbl[3] = '{1, 1, 1, 16'hA001, 8'h01, 1, 8'h02};
        tbl[4] = '{1, 1, 1, 16'hA002, 8'h02, 1, 8'h03};
        tbl[5] = '{1, 1, 1, 16'hA003, 8'h03, 1, 8'h04};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].fe, 1'b0, 8'h00, tbl[i].rdy);
            chk("tbl_valid", o_valid, tbl[i].e_valid);
            chk("tbl_data",  o_data,  tbl[i].e_data);
            chk("tbl_ipc",   o_pc,    tbl[i].e_pc);
            chk("tbl_cs",    o_cs,    tbl[i].e_cs);
            chk("tbl_addr",  o_addr,  tbl[i].e_addr);
        end

        // Backpressure fills exactly FIFO_DEPTH entries
        do_reset();
        ncs = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 8'h00, 0);
            ncs += int'(o_cs);
        end
        chk("full_req_count", ncs, 4);
        chk("full_head", o_data, 16'hA000);
        step(1, 0, 8'h00, 1);
        chk("full_pop_no_push", o_cs, 1'b0);
        step(1, 0, 8'h00, 1);
        chk("resume_cs", o_cs, 1'b1);
        chk("resume_addr", o_addr, 8'h04);
        repeat (4) step(1, 0, 8'h00, 1);

        // Redirect flushes a 3-entry FIFO
        do_reset();
        repeat (4) step(1, 0, 8'h00, 0);
        step(1, 1, 8'h40, 0);
        chk("redir_no_req", o_cs, 1'b0);
        step(1, 0, 8'h00, 0);
        chk("redir_valid", o_valid, 1'b0);
        chk("redir_addr", o_addr, 8'h40);
        step(1, 0, 8'h00, 1);
        chk("redir_ipc", o_pc, 8'h40);
        chk("redir_data", o_data, 16'hA040);

        // PC wrap
        do_reset();
        step(1, 1, 8'hFE, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'h00, 1);
            wrap_addr[i] = o_addr;
        end
        chk("wrap0", wrap_addr[0], 8'hFE);
        chk("wrap1", wrap_addr[1], 8'hFF);
        chk("wrap2", wrap_addr[2], 8'h00);
        chk("wrap3", wrap_addr[3], 8'h01);
        repeat (2) step(1, 0, 8'h00, 1);

        // fetch_en drop, drain in HOLD, then async reset mid-fetch
        do_reset();
        repeat (3) step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        chk("hold_cs", o_cs, 1'b0);
        repeat (4) step(0, 0, 8'h00, 1);
        chk("hold_drained", o_valid, 1'b0);
        repeat (3) step(1, 0, 8'h00, 1);
        pulse_reset();
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        chk("restart_addr", o_addr, 8'h00);
        chk("restart_cs", o_cs, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                 8'($urandom), $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
